dac_out_stage: RTL

Parametrised DAC output stage for the QAM transmitter. It accepts frames of NCH two's-complement baseband samples (I/Q by default) and supports four output modes: single-channel select, round-robin interleave, ramp test pattern and midscale mute. Each sample is rounded, saturated and converted to offset binary before it drives the DAC pins. It sits between the modulator/filter chain and the DAC pins, and generalises the fixed 16-bit select mux with width, channel count, mode control and a valid/ready handshake.

---
 rtl/dac_pkg.sv | 15 +
 rtl/dac_out_stage_fmt.sv | 34 +++
 rtl/dac_out_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dac_pkg.sv
// Shared mode encodings, interleave FSM states and the midscale helper for dac_out_stage.
package dac_pkg;

    localparam logic [1:0] MODE_SELECT     = 2'b00;
    localparam logic [1:0] MODE_INTERLEAVE = 2'b01;
    localparam logic [1:0] MODE_RAMP       = 2'b10;
    localparam logic [1:0] MODE_MUTE       = 2'b11;

    typedef enum logic {StIdle, StRun} state_e;

    function automatic logic [31:0] midscale(input int unsigned dac_w);
        return 32'd1 << (dac_w - 1);
    endfunction

endpackage

// File: rtl/dac_out_stage_fmt.sv
// Combinational sample formatter: round to nearest, saturate to the signed DAC range,
// then flip the MSB to get offset binary.
module dac_fmt #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DAC_W  = 14
) (
    input  logic [DATA_W-1:0] din,
    output logic [DAC_W-1:0]  dout
);

    localparam int unsigned SH = DATA_W - DAC_W;
    // Half an output LSB; zero when no bits are dropped.
    localparam logic signed [DATA_W:0] RND  = (DATA_W + 1)'((2 ** SH) >> 1);
    localparam logic signed [DATA_W:0] MAXV = (DATA_W + 1)'((2 ** (DAC_W - 1)) - 1);
    localparam logic signed [DATA_W:0] MINV = ~MAXV;

    logic signed [DATA_W:0] rnd;
    logic signed [DATA_W:0] shr;
    logic        [DAC_W-1:0] sat;

    always_comb begin
        rnd = $signed({din[DATA_W-1], din}) + RND;
        shr = rnd >>> SH;
        if (shr > MAXV) begin
            sat = {1'b0, {(DAC_W - 1){1'b1}}};
        end else if (shr < MINV) begin
            sat = {1'b1, {(DAC_W - 1){1'b0}}};
        end else begin
            sat = shr[DAC_W-1:0];
        end
        dout = {~sat[DAC_W-1], sat[DAC_W-2:0]};
    end

endmodule

// File: rtl/dac_out_stage.sv
// DAC output stage: select / interleave / ramp / mute modes with a valid-ready input
// and registered offset-binary output.
module dac_out_stage
    import dac_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DAC_W  = 14,
    parameter int unsigned NCH    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NCH*DATA_W-1:0]    in_data,
    input  logic [1:0]               mode,
    input  logic [$clog2(NCH)-1:0]   sel,
    input  logic                     underrun_clr,
    output logic [DAC_W-1:0]         dac_data,
    output logic                     dac_valid,
    output logic                     underrun
);

    localparam int unsigned         PH_W = $clog2(NCH);
    localparam logic [PH_W-1:0]     LAST = PH_W'(NCH - 1);
    localparam logic [DAC_W-1:0]    MID  = DAC_W'(midscale(DAC_W));

    state_e                  state_q, state_d;
    logic [PH_W-1:0]         ph_q, ph_d;
    logic [NCH*DATA_W-1:0]   frame_q, frame_d;
    logic [DAC_W-1:0]        ramp_q, ramp_d;
    logic [DAC_W-1:0]        dac_data_q, dac_data_d;
    logic                    dac_valid_q, dac_valid_d;
    logic                    underrun_q, underrun_d;
    logic [DATA_W-1:0]       fmt_in;
    logic [DAC_W-1:0]        fmt_out;

    function automatic logic [DATA_W-1:0] pick(input logic [NCH*DATA_W-1:0] fr,
                                               input logic [PH_W-1:0] idx);
        pick = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx == PH_W'(k)) pick = fr[k*DATA_W +: DATA_W];
        end
    endfunction

    dac_fmt #(
        .DATA_W (DATA_W),
        .DAC_W  (DAC_W)
    ) u_fmt (
        .din  (fmt_in),
        .dout (fmt_out)
    );

    // Mode is only honoured at a frame boundary, so a RUN frame always drains first.
    assign in_ready = !rst && ((state_q == StIdle) || (ph_q == LAST && mode == MODE_INTERLEAVE));

    always_comb begin
        fmt_in = pick(frame_q, ph_q);
        if (state_q == StIdle) fmt_in = pick(in_data, sel);
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        frame_d     = frame_q;
        ramp_d      = '0;
        dac_data_d  = dac_data_q;
        dac_valid_d = 1'b0;
        underrun_d  = underrun_q & ~underrun_clr;

        if (state_q == StRun) begin
            dac_data_d  = fmt_out;
            dac_valid_d = 1'b1;
            if (ph_q != LAST) begin
                ph_d = ph_q + PH_W'(1);
            end else if (mode == MODE_INTERLEAVE && in_valid) begin
                frame_d = in_data;
                ph_d    = '0;
            end else begin
                state_d = StIdle;
                ph_d    = '0;
                if (mode == MODE_INTERLEAVE) underrun_d = 1'b1;
            end
        end else begin
            unique case (mode)
                MODE_SELECT: begin
                    if (in_valid) begin
                        dac_data_d  = fmt_out;
                        dac_valid_d = 1'b1;
                    end
                end
                MODE_INTERLEAVE: begin
                    dac_data_d = MID;
                    if (in_valid) begin
                        frame_d = in_data;
                        state_d = StRun;
                        ph_d    = '0;
                    end
                end
                MODE_RAMP: begin
                    dac_data_d  = ramp_q;
                    dac_valid_d = 1'b1;
                    ramp_d      = ramp_q + DAC_W'(1);
                end
                MODE_MUTE: begin
                    dac_data_d  = MID;
                    dac_valid_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ph_q        <= '0;
            frame_q     <= '0;
            ramp_q      <= '0;
            dac_data_q  <= MID;
            dac_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            frame_q     <= frame_d;
            ramp_q      <= ramp_d;
            dac_data_q  <= dac_data_d;
            dac_valid_q <= dac_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign dac_data  = dac_data_q;
    assign dac_valid = dac_valid_q;
    assign underrun  = underrun_q;

endmodule
